// File: rtl/card_match_ctrl.sv
// Card-Flip game-play controller: latches the shuffled map, flips selected cards,
// compares pairs and tracks score. Optional miss counter: CARD_MATCH_MISS_CNT_EN.
module card_match_ctrl #(
    parameter int unsigned HOLD_CYCLES = 25_000_000,
    parameter int          MOVE_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              map_load,
    input  logic [0:47]       map,
    input  logic              sel_valid,
    input  logic [3:0]        sel_idx,
    output logic              sel_ready,
    output logic [15:0]       face_up,
    output logic [15:0]       matched,
    output logic [3:0]        pairs,
    output logic [MOVE_W-1:0] moves,
    output logic [MOVE_W-1:0] misses,
    output logic              game_over
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FIRST,
        WAIT_SECOND,
        COMPARE,
        SHOW,
        WIN
    } state_t;

    localparam logic [MOVE_W-1:0] CNT_ONE = {{(MOVE_W-1){1'b0}}, 1'b1};
    localparam logic [MOVE_W-1:0] CNT_MAX = {MOVE_W{1'b1}};
    localparam logic [31:0]       HOLD_LOAD = 32'(HOLD_CYCLES - 1);

    state_t            state_q, state_d;
    logic [0:47]       map_q, map_d;
    logic [3:0]        idx0_q, idx0_d;
    logic [3:0]        idx1_q, idx1_d;
    logic [31:0]       hold_q, hold_d;
    logic              sel_ready_q, sel_ready_d;
    logic [15:0]       face_up_q, face_up_d;
    logic [15:0]       matched_q, matched_d;
    logic [3:0]        pairs_q, pairs_d;
    logic [MOVE_W-1:0] moves_q, moves_d;
    logic              game_over_q, game_over_d;
`ifdef CARD_MATCH_MISS_CNT_EN
    logic [MOVE_W-1:0] misses_q, misses_d;
`endif

    logic       sel_accept;
    logic [2:0] val0, val1;

    // Card i occupies map[3i:3i+2] with the lowest-numbered bit as MSB.
    assign val0       = map_q[3*int'(idx0_q) +: 3];
    assign val1       = map_q[3*int'(idx1_q) +: 3];
    assign sel_accept = sel_valid && sel_ready_q && !face_up_q[sel_idx];

    always_comb begin
        state_d     = state_q;
        map_d       = map_q;
        idx0_d      = idx0_q;
        idx1_d      = idx1_q;
        hold_d      = hold_q;
        face_up_d   = face_up_q;
        matched_d   = matched_q;
        pairs_d     = pairs_q;
        moves_d     = moves_q;
        game_over_d = game_over_q;
`ifdef CARD_MATCH_MISS_CNT_EN
        misses_d    = misses_q;
`endif

        if (map_load) begin
            map_d       = map;
            face_up_d   = '0;
            matched_d   = '0;
            pairs_d     = '0;
            moves_d     = '0;
            game_over_d = 1'b0;
            hold_d      = '0;
`ifdef CARD_MATCH_MISS_CNT_EN
            misses_d    = '0;
`endif
            state_d     = WAIT_FIRST;
        end else begin
            case (state_q)
                WAIT_FIRST: begin
                    if (sel_accept) begin
                        idx0_d             = sel_idx;
                        face_up_d[sel_idx] = 1'b1;
                        state_d            = WAIT_SECOND;
                    end
                end
                WAIT_SECOND: begin
                    if (sel_accept) begin
                        idx1_d             = sel_idx;
                        face_up_d[sel_idx] = 1'b1;
                        moves_d            = (moves_q == CNT_MAX) ? moves_q : moves_q + CNT_ONE;
                        state_d            = COMPARE;
                    end
                end
                COMPARE: begin
                    if (val0 == val1) begin
                        matched_d[idx0_q] = 1'b1;
                        matched_d[idx1_q] = 1'b1;
                        pairs_d           = pairs_q + 4'd1;
                        if (pairs_q == 4'd7) begin
                            game_over_d = 1'b1;
                            state_d     = WIN;
                        end else begin
                            state_d = WAIT_FIRST;
                        end
                    end else begin
`ifdef CARD_MATCH_MISS_CNT_EN
                        misses_d = (misses_q == CNT_MAX) ? misses_q : misses_q + CNT_ONE;
`endif
                        hold_d  = HOLD_LOAD;
                        state_d = SHOW;
                    end
                end
                SHOW: begin
                    // Mismatched pair stays visible until the counter has run down from HOLD_CYCLES-1.
                    if (hold_q == '0) begin
                        face_up_d[idx0_q] = 1'b0;
                        face_up_d[idx1_q] = 1'b0;
                        state_d           = WAIT_FIRST;
                    end else begin
                        hold_d = hold_q - 32'd1;
                    end
                end
                default: ;
            endcase
        end

        sel_ready_d = (state_d == WAIT_FIRST) || (state_d == WAIT_SECOND);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            map_q       <= '0;
            idx0_q      <= '0;
            idx1_q      <= '0;
            hold_q      <= '0;
            sel_ready_q <= 1'b0;
            face_up_q   <= '0;
            matched_q   <= '0;
            pairs_q     <= '0;
            moves_q     <= '0;
            game_over_q <= 1'b0;
`ifdef CARD_MATCH_MISS_CNT_EN
            misses_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            map_q       <= map_d;
            idx0_q      <= idx0_d;
            idx1_q      <= idx1_d;
            hold_q      <= hold_d;
            sel_ready_q <= sel_ready_d;
            face_up_q   <= face_up_d;
            matched_q   <= matched_d;
            pairs_q     <= pairs_d;
            moves_q     <= moves_d;
            game_over_q <= game_over_d;
`ifdef CARD_MATCH_MISS_CNT_EN
            misses_q    <= misses_d;
`endif
        end
    end

    assign sel_ready = sel_ready_q;
    assign face_up   = face_up_q;
    assign matched   = matched_q;
    assign pairs     = pairs_q;
    assign moves     = moves_q;
    assign game_over = game_over_q;
`ifdef CARD_MATCH_MISS_CNT_EN
    assign misses    = misses_q;
`else
    assign misses    = '0;
`endif

endmodule

// File: tb/tb_card_match_ctrl.sv
// Scoreboard bench for card_match_ctrl: expected snapshots are queued as stimulus
// is driven and compared field by field when the DUT is sampled.
module tb_card_match_ctrl;

    localparam int unsigned HOLD = 4;
`ifdef CARD_MATCH_MISS_CNT_EN
    localparam logic [7:0] MISS_ONE = 8'd1;
`else
    localparam logic [7:0] MISS_ONE = 8'd0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        map_load = 1'b0;
    logic [0:47] map = '0;
    logic        sel_valid = 1'b0;
    logic [3:0]  sel_idx = '0;
    logic        sel_ready;
    logic [15:0] face_up;
    logic [15:0] matched;
    logic [3:0]  pairs;
    logic [7:0]  moves;
    logic [7:0]  misses;
    logic        game_over;

    card_match_ctrl #(.HOLD_CYCLES(HOLD), .MOVE_W(8)) dut (
        .clk(clk), .reset(reset), .map_load(map_load), .map(map),
        .sel_valid(sel_valid), .sel_idx(sel_idx), .sel_ready(sel_ready),
        .face_up(face_up), .matched(matched), .pairs(pairs), .moves(moves),
        .misses(misses), .game_over(game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [15:0] fu;
        logic [15:0] mt;
        logic [3:0]  pr;
        logic [7:0]  mv;
        logic [7:0]  ms;
        logic        go;
        logic        rdy;
    } snap_t;

    snap_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic pushExp(input string tag, input logic [15:0] fu, input logic [15:0] mt,
                           input logic [3:0] pr, input logic [7:0] mv, input logic [7:0] ms,
                           input logic go, input logic rdy);
        snap_t s;
        s.tag = tag; s.fu = fu; s.mt = mt; s.pr = pr; s.mv = mv; s.ms = ms; s.go = go; s.rdy = rdy;
        exp_q.push_back(s);
    endtask

    task automatic popAndCompare();
        snap_t s;
        if (exp_q.size() == 0) begin
            checkOutput("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        s = exp_q.pop_front();
        checkOutput({s.tag, ".face_up"},   32'(face_up),   32'(s.fu));
        checkOutput({s.tag, ".matched"},   32'(matched),   32'(s.mt));
        checkOutput({s.tag, ".pairs"},     32'(pairs),     32'(s.pr));
        checkOutput({s.tag, ".moves"},     32'(moves),     32'(s.mv));
        checkOutput({s.tag, ".misses"},    32'(misses),    32'(s.ms));
        checkOutput({s.tag, ".game_over"}, 32'(game_over), 32'(s.go));
        checkOutput({s.tag, ".sel_ready"}, 32'(sel_ready), 32'(s.rdy));
    endtask

    // Drives inputs for exactly one rising edge; returns at the following falling edge.
    task automatic applyStimulus(input logic v, input logic [3:0] idx, input logic ld, input logic rst);
        sel_valid = v;
        sel_idx   = idx;
        map_load  = ld;
        reset     = rst;
        @(negedge clk);
        sel_valid = 1'b0;
        map_load  = 1'b0;
        reset     = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 16; i++) map[3*i +: 3] = 3'(i >> 1);

        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        pushExp("reset", 16'h0, 16'h0, 4'd0, 8'd0, 8'd0, 1'b0, 1'b0);
        popAndCompare();

        pushExp("idle_select", 16'h0, 16'h0, 4'd0, 8'd0, 8'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd0, 1'b0, 1'b0);
        popAndCompare();

        pushExp("load", 16'h0, 16'h0, 4'd0, 8'd0, 8'd0, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
        popAndCompare();

        // Match: 0 then 1
        pushExp("match_first", 16'h0001, 16'h0, 4'd0, 8'd0, 8'd0, 1'b0, 1'b1);
        applyStimulus(1'b1, 4'd0, 1'b0, 1'b0);
        popAndCompare();
        pushExp("match_compare", 16'h0003, 16'h0, 4'd0, 8'd1, 8'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd1, 1'b0, 1'b0);
        popAndCompare();
        pushExp("match_done", 16'h0003, 16'h0003, 4'd1, 8'd1, 8'd0, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
        popAndCompare();

        // Mismatch: 2 then 4, with sel_valid held through SHOW
        applyStimulus(1'b1, 4'd2, 1'b0, 1'b0);
        pushExp("miss_compare", 16'h0017, 16'h0003, 4'd1, 8'd2, 8'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd4, 1'b0, 1'b0);
        popAndCompare();
        for (int c = 0; c < int'(HOLD); c++) begin
            pushExp($sformatf("miss_show%0d", c), 16'h0017, 16'h0003, 4'd1, 8'd2, MISS_ONE, 1'b0, 1'b0);
            applyStimulus(1'b1, 4'd6, 1'b0, 1'b0);
            popAndCompare();
        end
        pushExp("miss_clear", 16'h0003, 16'h0003, 4'd1, 8'd2, MISS_ONE, 1'b0, 1'b1);
        applyStimulus(1'b1, 4'd6, 1'b0, 1'b0);
        popAndCompare();

        // Illegal selects: repeat card 3, then an already-matched card
        applyStimulus(1'b1, 4'd3, 1'b0, 1'b0);
        pushExp("repeat_sel", 16'h000B, 16'h0003, 4'd1, 8'd2, MISS_ONE, 1'b0, 1'b1);
        applyStimulus(1'b1, 4'd3, 1'b0, 1'b0);
        popAndCompare();
        pushExp("matched_sel", 16'h000B, 16'h0003, 4'd1, 8'd2, MISS_ONE, 1'b0, 1'b1);
        applyStimulus(1'b1, 4'd0, 1'b0, 1'b0);
        popAndCompare();
        applyStimulus(1'b1, 4'd2, 1'b0, 1'b0);
        pushExp("pair_32", 16'h000F, 16'h000F, 4'd2, 8'd3, MISS_ONE, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
        popAndCompare();

        // Full game from a fresh load
        pushExp("reload", 16'h0, 16'h0, 4'd0, 8'd0, 8'd0, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
        popAndCompare();
        for (int k = 0; k < 8; k++) begin
            logic [15:0] mask;
            mask = 16'((32'd1 << (2*k + 2)) - 1);
            applyStimulus(1'b1, 4'(2*k), 1'b0, 1'b0);
            applyStimulus(1'b1, 4'(2*k + 1), 1'b0, 1'b0);
            pushExp($sformatf("game_pair%0d", k), mask, mask, 4'(k + 1), 8'(k + 1), 8'd0,
                    (k == 7), (k != 7));
            applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
            popAndCompare();
        end
        applyStimulus(1'b1, 4'd5, 1'b0, 1'b0);
        pushExp("win_hold", 16'hFFFF, 16'hFFFF, 4'd8, 8'd8, 8'd0, 1'b1, 1'b0);
        applyStimulus(1'b1, 4'd9, 1'b0, 1'b0);
        popAndCompare();

        // Restart mid-SHOW
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
        applyStimulus(1'b1, 4'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd2, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
        pushExp("in_show", 16'h0005, 16'h0, 4'd0, 8'd1, MISS_ONE, 1'b0, 1'b0);
        popAndCompare();
        pushExp("restart", 16'h0, 16'h0, 4'd0, 8'd0, 8'd0, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
        popAndCompare();
        pushExp("restart_first", 16'h0001, 16'h0, 4'd0, 8'd0, 8'd0, 1'b0, 1'b1);
        applyStimulus(1'b1, 4'd0, 1'b0, 1'b0);
        popAndCompare();

        // Reset mid-WAIT_SECOND, then selections ignored
        pushExp("reset_mid", 16'h0, 16'h0, 4'd0, 8'd0, 8'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd1, 1'b0, 1'b1);
        popAndCompare();
        pushExp("post_reset_sel", 16'h0, 16'h0, 4'd0, 8'd0, 8'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd5, 1'b0, 1'b0);
        popAndCompare();

        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/card_match_ctrl.md
# card_match_ctrl

Game-play controller for Card-Flip that sits directly downstream of `random_assign`. On the `done` pulse it captures the 48-bit shuffled map of 16 cards × 3-bit face values. It then takes player card selections, flips cards, and compares pairs. Mismatched pairs stay visible for a hold time, and the block tracks matched pairs, moves and game completion for the display and score logic.

## Interface
Parameters:
- `HOLD_CYCLES`, default 25_000_000: cycles a mismatched pair stays face-up; legal range 1..2^32-1.
- `MOVE_W`, default 8: width of the `moves` and `misses` counters.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `map_load`  in  1  one-cycle pulse (driven by `random_assign` `done`); latches `map` and starts a new game.
- `map`  in  [0:47]  card i value = `map[3i : 3i+2]`, with `map[3i]` as MSB.
- `sel_valid`  in  1  player selection strobe.
- `sel_idx`  in  4  selected card index 0..15.
- `sel_ready`  out  1  high in WAIT_FIRST and WAIT_SECOND.
- `face_up`  out  16  bit i = card i currently shown (includes matched cards).
- `matched`  out  16  bit i = card i permanently matched.
- `pairs`  out  4  matched pair count 0..8.
- `moves`  out  MOVE_W  completed pair attempts; saturates at all-ones.
- `misses`  out  MOVE_W  mismatched attempts (see Configuration).
- `game_over`  out  1  high in WIN.

## Operation
- States: IDLE, WAIT_FIRST, WAIT_SECOND, COMPARE, SHOW, WIN.
- Reset:
  - All outputs are 0 and the state is IDLE.
  - The internal map copy, first/second index registers and hold counter are cleared.
- `map_load`, in any state including IDLE and mid-game:
  - Latch `map`.
  - Clear `face_up`, `matched`, `pairs`, `moves`, `misses`, `game_over` and the hold counter.
  - Next state is WAIT_FIRST.
  - `map_load` has priority over every other event in the same cycle.
- Selection acceptance:
  - A selection is accepted when `sel_valid && sel_ready && !face_up[sel_idx]`.
  - Selections of face-up or matched cards are dropped silently.
  - `sel_valid` outside WAIT_FIRST/WAIT_SECOND is ignored. Nothing is queued.
- WAIT_FIRST + accept: store `idx0`, set `face_up[idx0]`, go to WAIT_SECOND.
- WAIT_SECOND + accept:
  - Store `idx1` and set `face_up[idx1]`.
  - `moves` += 1 (saturating).
  - Go to COMPARE.
- COMPARE: compare the latched values of `idx0` and `idx1`.
  - Equal: set `matched[idx0]` and `matched[idx1]`; `pairs` += 1. Go to WIN if `pairs` becomes 8, else WAIT_FIRST.
  - Unequal: `misses` += 1 (if enabled); load the hold counter with HOLD_CYCLES-1; go to SHOW.
- SHOW:
  - The hold counter decrements each cycle.
  - At 0: clear `face_up[idx0]` and `face_up[idx1]`, go to WAIT_FIRST.
- WIN: hold all outputs; leave only on `map_load` or `reset`.
- Values equal in the map are treated as a match regardless of how many cards share the value.

## Timing
- Accepted selection → `face_up` bit visible on the next edge.
- Second accept at edge N:
  - `moves` updates at N.
  - COMPARE occupies cycle N.
  - `matched`/`pairs` update at edge N+1, or SHOW is entered at N+1.
- Mismatch:
  - SHOW lasts exactly HOLD_CYCLES cycles.
  - `face_up` clears at edge N+1+HOLD_CYCLES.
  - `sel_ready` re-asserts in the same cycle.
- `game_over` rises at the edge where `pairs` goes 7→8.
- `sel_ready` is registered and low during COMPARE, SHOW, WIN and IDLE.
- A `reset` mid-SHOW or mid-game takes effect at the next edge; no partial state survives.

## Configuration
- `CARD_MATCH_MISS_CNT_EN` defined:
  - `misses` counts mismatches, saturating at all-ones.
  - `misses` is cleared by `reset`/`map_load`.
- Not defined: the `misses` port still exists, is tied to 0, and has no counter register. All other behaviour is identical.

## Test plan
All scenarios use HOLD_CYCLES=4 and a map where card i value = i>>1 (cards 0/1 hold 0, cards 14/15 hold 7).
- Match:
  - Stimulus: `map_load`, select 0 then 1.
  - Required: `face_up`=0x0003, `matched`=0x0003, `pairs`=1, `moves`=1, back in WAIT_FIRST.
- Mismatch:
  - Stimulus: select 0 then 2.
  - Required: `face_up`=0x0005 for COMPARE + 4 SHOW cycles, then 0x0000; `misses`=1 when enabled, 0 when not; `sel_ready` low throughout.
- Illegal selects:
  - Stimulus: select 3 twice; `sel_valid` during SHOW; select an already-matched card.
  - Required: all ignored; `moves` and state unchanged.
- Full game:
  - Stimulus: pairs (0,1),(2,3)…(14,15).
  - Required: `pairs`=8, `moves`=8, `matched`=0xFFFF, `game_over`=1; later selects ignored.
- Restart and reset:
  - Stimulus: `map_load` mid-SHOW.
  - Required: all counters and masks 0, state WAIT_FIRST.
  - Stimulus: `reset` asserted mid-WAIT_SECOND.
  - Required: all outputs 0, IDLE; selections ignored until `map_load`.
